// File: rtl/scope_buf_pkg.sv
// -----------------------------------------------------------------------------
// scope_buf_pkg
// Shared definitions for the scope trigger line buffer:
//   - capture FSM state encoding (3 bits, exposed on state_o)
//   - trigger slope constants
//   - trig_hit(): edge-crossing compare used in the WAIT state
// No ports (package).
// -----------------------------------------------------------------------------
package scope_buf_pkg;

   localparam logic [2:0] ST_ROLL    = 3'd0;
   localparam logic [2:0] ST_FROZEN  = 3'd1;
   localparam logic [2:0] ST_PREFILL = 3'd2;
   localparam logic [2:0] ST_WAIT    = 3'd3;
   localparam logic [2:0] ST_POST    = 3'd4;

   localparam logic SLOPE_RISE = 1'b0;
   localparam logic SLOPE_FALL = 1'b1;

   // Operands are zero-extended to 32 bits by the caller so one function
   // serves any sample width; all compares are unsigned.
   // Rising:  prev < level <= cur      Falling: prev > level >= cur
   function automatic logic trig_hit(input logic        slope,
                                     input logic [31:0] prev,
                                     input logic [31:0] cur,
                                     input logic [31:0] level);
      if (slope == SLOPE_RISE)
         return (prev < level) && (level <= cur);
      else
         return (prev > level) && (level >= cur);
   endfunction

endpackage

// File: rtl/cdc_bus_handshake.sv
// -----------------------------------------------------------------------------
// cdc_bus_handshake
// Toggle req/ack bus synchroniser. Safe for arbitrary value jumps because
// the bus is only sampled by the destination after a full handshake.
//
// Handshake: a word is accepted on a src_clk edge where src_valid && src_ready.
// src_ready is high while the channel is idle (synchronised ack == req);
// src_valid may be asserted or dropped at any time, and the held word
// (src_hold) stays stable from acceptance until the ack returns.
//
// Ports:
//   src_clk, src_rst_n   source clock / async active-low reset
//   src_valid            source has a new word to send
//   src_ready            channel idle, word will be accepted this edge
//   src_data  [W]        word to send
//   src_hold  [W]        word currently held for / last sent to destination
//   dst_clk, dst_rst_n   destination clock / async active-low reset
//   dst_data  [W]        last word delivered into the destination domain
// -----------------------------------------------------------------------------
module cdc_bus_handshake #(
   parameter int W = 8
) (
   input  logic         src_clk,
   input  logic         src_rst_n,
   input  logic         src_valid,
   output logic         src_ready,
   input  logic [W-1:0] src_data,
   output logic [W-1:0] src_hold,
   input  logic         dst_clk,
   input  logic         dst_rst_n,
   output logic [W-1:0] dst_data
);

   logic         req;
   logic         ack_s1, ack_s2;
   logic [W-1:0] hold;
   logic         req_s1, req_s2, req_s3;
   logic         ack;

   assign src_ready = (ack_s2 == req);
   assign src_hold  = hold;

   always_ff @(posedge src_clk or negedge src_rst_n) begin
      if (!src_rst_n) begin
         req    <= 1'b0;
         hold   <= '0;
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
      end else begin
         ack_s1 <= ack;
         ack_s2 <= ack_s1;
         if (src_valid && src_ready) begin
            hold <= src_data;
            req  <= ~req;
         end
      end
   end

   // hold is quasi-static here: it only changes after ack has come back,
   // so sampling it on a detected req edge is safe.
   always_ff @(posedge dst_clk or negedge dst_rst_n) begin
      if (!dst_rst_n) begin
         req_s1   <= 1'b0;
         req_s2   <= 1'b0;
         req_s3   <= 1'b0;
         ack      <= 1'b0;
         dst_data <= '0;
      end else begin
         req_s1 <= req;
         req_s2 <= req_s1;
         req_s3 <= req_s2;
         if (req_s2 != req_s3) begin
            dst_data <= hold;
            ack      <= ~ack;
         end
      end
   end

endmodule

// File: rtl/scope_trig_linebuf.sv
// -----------------------------------------------------------------------------
// scope_trig_linebuf
// Multi-channel circular sample buffer between the ADC (wr_clk) and the LCD
// renderer (rd_clk). Roll mode scrolls continuously; triggered mode runs
// PREFILL -> WAIT -> POST -> FROZEN so the trigger sample lands at column PRE.
//
// Ports:
//   wr_clk, wr_rst_n    write clock / async active-low reset
//   rd_clk, rd_rst_n    pixel clock / async active-low reset
//   wr_en               one sample set this cycle
//   wr_data [CH*DW]     channel c at [c*DW +: DW]
//   mode                0 = roll, 1 = triggered
//   arm                 pulse: (re)start a capture
//   trig_ch [TW]        channel compared against trig_level
//   trig_level [DW]     unsigned threshold
//   trig_slope          0 = rising, 1 = falling
//   state_o [3]         FSM state (scope_buf_pkg encoding)
//   trig_pulse          one cycle after the trigger sample is written
//   done_pulse          one cycle on POST -> FROZEN
//   rd_x [AW]           screen column
//   rd_data [CH*DW]     samples for rd_x, one rd_clk later; 0 for rd_x >= DEPTH
//   rd_frozen           FROZEN, synchronised into rd_clk
// -----------------------------------------------------------------------------
module scope_trig_linebuf
   import scope_buf_pkg::*;
#(
   parameter int CH    = 2,
   parameter int DW    = 8,
   parameter int DEPTH = 800,
   parameter int AW    = $clog2(DEPTH),
   parameter int PRE   = DEPTH / 2,
   parameter int TW    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic               wr_clk,
   input  logic               wr_rst_n,
   input  logic               rd_clk,
   input  logic               rd_rst_n,
   input  logic               wr_en,
   input  logic [CH*DW-1:0]   wr_data,
   input  logic               mode,
   input  logic               arm,
   input  logic [TW-1:0]      trig_ch,
   input  logic [DW-1:0]      trig_level,
   input  logic               trig_slope,
   output logic [2:0]         state_o,
   output logic               trig_pulse,
   output logic               done_pulse,
   input  logic [AW-1:0]      rd_x,
   output logic [CH*DW-1:0]   rd_data,
   output logic               rd_frozen
);

   localparam int             POST_LEN  = DEPTH - PRE - 1;
   localparam logic [AW-1:0]  IDX_LAST  = AW'(DEPTH - 1);
   localparam logic [AW-1:0]  PRE_LAST  = AW'(PRE - 1);
   localparam logic [AW-1:0]  POST_LAST = AW'(POST_LEN - 1);
   localparam logic [AW:0]    DEPTH_W   = (AW+1)'(DEPTH);

   logic [2:0]       state;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    cnt;
   logic [DW-1:0]    prev;
   logic             prev_valid;
   logic [DW-1:0]    cur;
   logic             wr_fire;
   logic             wr_frozen;
   logic             frz_s1, frz_s2;
   logic [AW-1:0]    base_hold;
   logic             base_ready;
   logic [AW-1:0]    rd_base;
   logic [AW:0]      rd_sum;
   logic [AW-1:0]    rd_addr;

   logic [CH*DW-1:0] mem [DEPTH];

   assign state_o = state;
   assign wr_fire = wr_en && (state != ST_FROZEN);

   always_comb begin
      cur = '0;
      for (int c = 0; c < CH; c++)
         if (TW'(c) == trig_ch) cur = wr_data[c*DW +: DW];
   end

   always_ff @(posedge wr_clk) begin
      if (wr_fire) mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state      <= ST_ROLL;
         wr_idx     <= '0;
         cnt        <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
         trig_pulse <= 1'b0;
         done_pulse <= 1'b0;
         wr_frozen  <= 1'b0;
      end else begin
         trig_pulse <= 1'b0;
         done_pulse <= 1'b0;
         wr_frozen  <= (state == ST_FROZEN);
         if (wr_fire) begin
            wr_idx     <= (wr_idx == IDX_LAST) ? '0 : wr_idx + 1'b1;
            prev       <= cur;
            prev_valid <= 1'b1;
         end
         if (!mode) begin
            state <= ST_ROLL;
         end else if (arm) begin
            // Restart from any state; prev_valid clear overrides the write above.
            state      <= ST_PREFILL;
            cnt        <= '0;
            prev_valid <= 1'b0;
         end else begin
            case (state)
               ST_ROLL:    state <= ST_FROZEN;
               ST_PREFILL: if (wr_fire) begin
                  if (cnt == PRE_LAST) begin
                     state <= ST_WAIT;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_WAIT: if (wr_fire && prev_valid &&
                            trig_hit(trig_slope, 32'(prev), 32'(cur), 32'(trig_level))) begin
                  trig_pulse <= 1'b1;
                  cnt        <= '0;
                  state      <= (POST_LEN == 0) ? ST_FROZEN : ST_POST;
               end
               ST_POST: if (wr_fire) begin
                  if (cnt == POST_LAST) begin
                     state      <= ST_FROZEN;
                     done_pulse <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_FROZEN:  ;
               default:    state <= ST_ROLL;
            endcase
         end
      end
   end

   // wr_idx is always the oldest sample, so it is the display base.
   cdc_bus_handshake #(.W(AW)) u_base_cdc (
      .src_clk   (wr_clk),
      .src_rst_n (wr_rst_n),
      .src_valid (wr_idx != base_hold),
      .src_ready (base_ready),
      .src_data  (wr_idx),
      .src_hold  (base_hold),
      .dst_clk   (rd_clk),
      .dst_rst_n (rd_rst_n),
      .dst_data  (rd_base)
   );

   // Both operands are < 2^AW, and rd_x >= DEPTH is blanked, so a single
   // conditional subtract is enough for the wrap.
   assign rd_sum  = {1'b0, rd_base} + {1'b0, rd_x};
   assign rd_addr = (rd_sum >= DEPTH_W) ? AW'(rd_sum - DEPTH_W) : rd_sum[AW-1:0];

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         rd_data <= '0;
         frz_s1  <= 1'b0;
         frz_s2  <= 1'b0;
      end else begin
         frz_s1 <= wr_frozen;
         frz_s2 <= frz_s1;
         if ({1'b0, rd_x} >= DEPTH_W) rd_data <= '0;
         else                         rd_data <= mem[rd_addr];
      end
   end

   assign rd_frozen = frz_s2;

endmodule

// File: tb/tb_scope_trig_linebuf.sv
module tb_scope_trig_linebuf;

   localparam int CH = 2, DW = 8, DEPTH = 800, AW = 10, PRE = 400, TW = 1;

   logic             wr_clk = 1'b0, rd_clk = 1'b0;
   logic             wr_rst_n = 1'b0, rd_rst_n = 1'b0;
   logic             wr_en = 1'b0;
   logic [CH*DW-1:0] wr_data = '0;
   logic             mode = 1'b0, arm = 1'b0;
   logic [TW-1:0]    trig_ch = '0;
   logic [DW-1:0]    trig_level = '0;
   logic             trig_slope = 1'b0;
   logic [2:0]       state_o;
   logic             trig_pulse, done_pulse;
   logic [AW-1:0]    rd_x = '0;
   logic [CH*DW-1:0] rd_data;
   logic             rd_frozen;

   scope_trig_linebuf #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .AW(AW), .PRE(PRE), .TW(TW)) dut (
      .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
      .wr_en(wr_en), .wr_data(wr_data), .mode(mode), .arm(arm),
      .trig_ch(trig_ch), .trig_level(trig_level), .trig_slope(trig_slope),
      .state_o(state_o), .trig_pulse(trig_pulse), .done_pulse(done_pulse),
      .rd_x(rd_x), .rd_data(rd_data), .rd_frozen(rd_frozen)
   );

   // ---------------- clock / reset ----------------
   always #5 wr_clk = ~wr_clk;
   always #7 rd_clk = ~rd_clk;

   // ---------------- scoreboard ----------------
   int checks = 0, failures = 0;
   int nwr = 0, trig_at = -1, done_at = -1, n_trig = 0, n_done = 0;

   typedef struct {
      logic [AW-1:0]    x;
      logic [CH*DW-1:0] exp;
   } vec_t;
   vec_t tbl [14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge wr_clk);
      #1;
      if (trig_pulse) begin n_trig++; trig_at = nwr; end
      if (done_pulse) begin n_done++; done_at = nwr; end
   endtask

   task automatic wr_one(input logic [CH*DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      nwr++;
      wr_en = 1'b0;
   endtask

   task automatic arm_pulse();
      mode = 1'b1;
      arm  = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic start_capture();
      nwr = 0; trig_at = -1; done_at = -1; n_trig = 0; n_done = 0;
   endtask

   task automatic settle();
      repeat (30) @(posedge rd_clk);
   endtask

   task automatic read_col(input logic [AW-1:0] x, output logic [CH*DW-1:0] got);
      @(posedge rd_clk); #1;
      rd_x = x;
      @(posedge rd_clk); #1;
      got = rd_data;
   endtask

   task automatic apply_vecs(input int lo, input int hi, input string tag);
      logic [CH*DW-1:0] got;
      for (int i = lo; i <= hi; i++) begin
         read_col(tbl[i].x, got);
         check($sformatf("%s x=%0d", tag, tbl[i].x), 32'(got), 32'(tbl[i].exp));
      end
   endtask

   // ---------------- test ----------------
   initial begin
      logic [7:0]       b;
      logic [CH*DW-1:0] got;
      int               bad;

      // Roll: 1000 writes of {~i, i}; base ends at 200.
      tbl[0]  = '{10'd0,    16'h37C8};
      tbl[1]  = '{10'd799,  16'h18E7};
      tbl[2]  = '{10'd1,    16'h36C9};
      tbl[3]  = '{10'd600,  16'hDF20};
      tbl[4]  = '{10'd599,  16'hE01F};
      tbl[5]  = '{10'd800,  16'h0000};
      tbl[6]  = '{10'd1023, 16'h0000};
      // Triggered ramp: column x shows capture write 240+x, trigger at x=400.
      tbl[7]  = '{10'd0,    16'h0FF0};
      tbl[8]  = '{10'd15,   16'h00FF};
      tbl[9]  = '{10'd16,   16'hFF00};
      tbl[10] = '{10'd399,  16'h807F};
      tbl[11] = '{10'd400,  16'h7F80};
      tbl[12] = '{10'd799,  16'hF00F};
      tbl[13] = '{10'd900,  16'h0000};

      // Reset state
      repeat (3) @(posedge wr_clk);
      #1;
      check("rst state_o", 32'(state_o), 32'd0);
      check("rst trig_pulse", 32'(trig_pulse), 32'd0);
      check("rst done_pulse", 32'(done_pulse), 32'd0);
      check("rst rd_data", 32'(rd_data), 32'd0);
      check("rst rd_frozen", 32'(rd_frozen), 32'd0);
      wr_rst_n = 1'b1;
      rd_rst_n = 1'b1;
      tick();

      // Roll mode strip chart
      for (int i = 0; i < 1000; i++) begin
         b = 8'(i);
         wr_one({~b, b});
      end
      settle();
      check("roll state", 32'(state_o), 32'd0);
      check("roll rd_frozen", 32'(rd_frozen), 32'd0);
      apply_vecs(0, 6, "roll");

      // Triggered rising ramp on ch0, level 128
      trig_ch = 1'b0; trig_slope = 1'b0; trig_level = 8'd128;
      arm_pulse();
      check("arm -> PREFILL", 32'(state_o), 32'd2);
      start_capture();
      for (int j = 0; j < 1040; j++) begin
         b = 8'(j);
         wr_one({~b, b});
         if (j == 399) check("prefill -> WAIT", 32'(state_o), 32'd3);
      end
      check("rise n_trig", 32'(n_trig), 32'd1);
      check("rise trig_at", 32'(trig_at), 32'd640);
      check("rise done_at", 32'(done_at), 32'd1039);
      check("rise done-trig", 32'(done_at - trig_at), 32'd399);
      check("rise n_done", 32'(n_done), 32'd1);
      check("rise FROZEN", 32'(state_o), 32'd1);
      settle();
      check("rise rd_frozen", 32'(rd_frozen), 32'd1);
      apply_vecs(7, 13, "frozen");

      // FROZEN ignores writes
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         wr_en   = i[0];
         wr_data = 16'($urandom);
         tick();
         if (state_o != 3'd1) bad++;
      end
      wr_en = 1'b0;
      check("frozen hold state", 32'(bad), 32'd0);
      settle();
      check("frozen hold rd_frozen", 32'(rd_frozen), 32'd1);
      apply_vecs(7, 13, "frozen-after");

      // Falling trigger on ch1 while ch0 toggles across the level
      trig_ch = 1'b1; trig_slope = 1'b1; trig_level = 8'd100;
      arm_pulse();
      start_capture();
      for (int k = 0; k < 810; k++) begin
         b = (k % 2 == 1) ? 8'd255 : 8'd0;
         wr_one({(k < 410) ? 8'd200 : ((k == 410) ? 8'd100 : 8'd50), b});
      end
      check("fall n_trig", 32'(n_trig), 32'd1);
      check("fall trig_at", 32'(trig_at), 32'd410);
      check("fall done_at", 32'(done_at), 32'd809);
      check("fall FROZEN", 32'(state_o), 32'd1);
      settle();
      read_col(10'd400, got); check("fall x=400", 32'(got), 32'h6400);
      read_col(10'd399, got); check("fall x=399", 32'(got), 32'hC8FF);
      read_col(10'd401, got); check("fall x=401", 32'(got), 32'h32FF);

      // Re-arm during POST aborts the capture
      trig_ch = 1'b0; trig_slope = 1'b0; trig_level = 8'd128;
      arm_pulse();
      start_capture();
      for (int j = 0; j < 400; j++) wr_one(16'h0000);
      check("rearm WAIT", 32'(state_o), 32'd3);
      wr_one(16'h00C8);
      check("rearm trig", 32'(n_trig), 32'd1);
      for (int j = 0; j < 50; j++) wr_one(16'h0000);
      check("rearm in POST", 32'(state_o), 32'd4);
      arm_pulse();
      check("rearm -> PREFILL", 32'(state_o), 32'd2);
      for (int j = 0; j < 399; j++) wr_one(16'h0000);
      check("rearm prefill cnt", 32'(state_o), 32'd2);
      wr_one(16'h0000);
      check("rearm prefill done", 32'(state_o), 32'd3);
      for (int j = 0; j < 50; j++) wr_one(16'h0000);
      check("rearm still WAIT", 32'(state_o), 32'd3);
      check("rearm no done", 32'(n_done), 32'd0);

      // Reset mid-capture, right as trig_pulse is high
      wr_one(16'h00C8);
      check("pre-rst trig_pulse", 32'(trig_pulse), 32'd1);
      #2;
      wr_rst_n = 1'b0;
      mode     = 1'b0;
      #1;
      check("mid-rst state", 32'(state_o), 32'd0);
      check("mid-rst trig_pulse", 32'(trig_pulse), 32'd0);
      check("mid-rst done_pulse", 32'(done_pulse), 32'd0);
      repeat (5) @(posedge wr_clk);
      @(negedge wr_clk);
      wr_rst_n = 1'b1;
      for (int i = 0; i < 5; i++) wr_one({8'h0B, 8'(8'hA0 + i)});
      check("post-rst ROLL", 32'(state_o), 32'd0);
      settle();
      read_col(10'd795, got); check("post-rst x=795", 32'(got), 32'h0BA0);
      read_col(10'd797, got); check("post-rst x=797", 32'(got), 32'h0BA2);
      read_col(10'd799, got); check("post-rst x=799", 32'(got), 32'h0BA4);

      // Roll -> FROZEN keeps the buffer and base
      mode = 1'b1;
      tick();
      check("roll->FROZEN", 32'(state_o), 32'd1);
      settle();
      read_col(10'd797, got); check("roll-frz x=797", 32'(got), 32'h0BA2);
      check("roll-frz rd_frozen", 32'(rd_frozen), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/scope_trig_linebuf.md
# scope_trig_linebuf

Multi-channel circular sample buffer between the ADC capture path (wr_clk) and the LCD waveform renderer (pixel clock). It has two modes. Roll mode behaves as a continuously scrolling strip chart. Triggered mode runs an arm → pre-fill → trigger → post-fill → freeze sequence, after which the screen shows a stable capture with the trigger point at a fixed column. Channel count, sample width, depth and pre-trigger length are parameters.

## Interface
Parameters:
- CH, 2: number of channels sharing one write strobe
- DW, 8: sample width
- DEPTH, 800: samples per channel, equal to screen columns
- AW, $clog2(DEPTH): address/pointer width
- PRE, DEPTH/2: pre-trigger sample count, legal range 1..DEPTH-1
- TW, (CH>1 ? $clog2(CH) : 1): trigger channel select width

Ports:
- wr_clk  in  1  write/ADC clock
- wr_rst_n  in  1  asynchronous, active-low reset for the wr_clk domain
- rd_clk  in  1  LCD pixel clock
- rd_rst_n  in  1  asynchronous, active-low reset for the rd_clk domain
- wr_en  in  1  one valid sample set per cycle
- wr_data  in  CH*DW  channel c occupies bits [c*DW +: DW]
- mode  in  1  0 = roll, 1 = triggered (wr domain)
- arm  in  1  single-cycle pulse; starts a capture
- trig_ch  in  TW  channel compared against the trigger level
- trig_level  in  DW  unsigned trigger threshold
- trig_slope  in  1  0 = rising, 1 = falling
- state_o  out  3  current FSM state; reset ROLL
- trig_pulse  out  1  one cycle high on the trigger sample; reset 0
- done_pulse  out  1  one cycle high on the POST→FROZEN transition; reset 0
- rd_x  in  AW  screen column
- rd_data  out  CH*DW  samples for column rd_x; reset 0
- rd_frozen  out  1  state==FROZEN, synchronised into rd_clk; reset 0

## Operation
- Storage: one DEPTH × (CH*DW) simple dual-port RAM. Write port is on wr_clk; registered read is on rd_clk.
- wr_idx is the next write address. It resets to 0 and wraps from DEPTH-1 to 0.
- Writing states are ROLL, PREFILL, WAIT, POST. A write occurs when wr_en is high in a writing state. The FROZEN state never writes.
- FSM encoding (shared package): ROLL=0, FROZEN=1, PREFILL=2, WAIT=3, POST=4.
- mode=0 in any state forces ROLL on the next edge, overriding everything else.
- ROLL with mode=1 goes to FROZEN. The buffer and base are retained.
- Any state with mode=1 and arm goes to PREFILL. A re-arm mid-capture restarts the capture. Entering PREFILL clears cnt and prev_valid.
- PREFILL: cnt counts writes. After the PRE-th write the FSM goes to WAIT.
- WAIT: on each write, compare prev (last trig_ch sample) against cur.
  - Rising trigger: prev < level ≤ cur.
  - Falling trigger: prev > level ≥ cur.
  - The comparison requires prev_valid, which is set by the first write after PREFILL entry.
  - On a hit, assert trig_pulse and reload cnt; the next state is POST. If DEPTH-PRE-1 == 0, go directly to FROZEN.
- POST: after DEPTH-PRE-1 further writes, go to FROZEN and pulse done_pulse.
- base_live = wr_idx, which is always the oldest sample. In FROZEN the trigger sample is at base + PRE, so it appears at column PRE.
- Base CDC uses toggle req/ack (sub-module), so it is valid for arbitrary pointer jumps:
  - When the channel is idle and base_live ≠ base_hold, latch base_hold and toggle req.
  - The rd side 2-flop-syncs req. On an edge it loads rd_base ← base_hold and toggles ack.
  - The wr side 2-flop-syncs ack. The channel is idle when ack_sync == req.
- Read: rd_addr = (rd_base + rd_x) mod DEPTH, computed as an AW+1-bit sum with a single conditional subtract.
  - rd_x ≥ DEPTH: rd_data is 0.
- rd_frozen: 2-flop synchroniser of (state==FROZEN).

## Timing
- Write, state update, trig_pulse and done_pulse all occur on the same wr_clk edge that consumes the sample.
- rd_data is valid 1 rd_clk after rd_x.
- rd_base update latency: ≤ 3 rd_clk after req toggles. The next transfer may start ≤ 3 wr_clk after the ack edge.
- base_hold is stable from req toggle until the ack returns.
- Roll mode: the displayed base may lag base_live by one transfer period. This is accepted.
- Reset mid-capture: wr side returns to ROLL with wr_idx=0 and req=0. The rd side keeps its base until rd_rst_n.
- Both resets must be asserted together at power-up.
- RAM contents are not reset.

## Structure
- Package scope_buf_pkg: state encoding, slope constants SLOPE_RISE=0 and SLOPE_FALL=1, and a trigger-compare function.
- Sub-module cdc_bus_handshake #(W): toggle req/ack bus synchroniser with src/dst clocks and resets, src_valid/src_ready, dst_data.
- Top-level contents: FSM, counters, trigger compare, RAM, read mapping.

## Test plan
- Roll, DEPTH=800, 1000 writes of value = index mod 256. After settle, expect rd_x=0 → 200 mod 256 = 200 and rd_x=799 → 999 mod 256 = 231.
- Triggered, PRE=400, level=128, rising ramp 0..255 on ch0 after arm.
  - trig_pulse on the sample equal to 128 (prev 127).
  - done_pulse exactly 399 writes later.
  - rd_x=400 returns 128 on ch0.
- Falling slope, trig_ch=1, with ch0 noise crossing the level. Expect the trigger to occur only on the ch1 crossing, and ch0 crossings to be ignored.
- Re-arm pulse during POST. Expect state → PREFILL, cnt restart, and no done_pulse from the aborted capture.
- In FROZEN, toggle wr_en for 2000 cycles. Expect the RAM unchanged, a constant rd_data map, and rd_frozen=1.
- Assert wr_rst_n during WAIT. Expect state_o=ROLL, trig_pulse=0, done_pulse=0 immediately. After release, roll writes resume at address 0.
